// File: rtl/jtag_cmd_sequencer_pkg.sv
// Shared types for the UART-to-JTAG command sequencer.
// Opcodes, engine operations, ack layout and FSM states.
package jtag_cmd_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_TAP_RESET = 4'd1,
        OP_SHIFT_IR  = 4'd2,
        OP_SHIFT_DR  = 4'd3
    } opcode_t;

    typedef enum logic [1:0] {
        ENG_TAP_RESET = 2'd0,
        ENG_SHIFT_IR  = 2'd1,
        ENG_SHIFT_DR  = 2'd2
    } eng_op_t;

    localparam int ACK_ILLEGAL_BIT = 0;
    localparam int ACK_TIMEOUT_BIT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_RSP,
        S_DRAIN,
        S_ACK
    } state_t;

    function automatic eng_op_t to_eng_op(input logic [3:0] instr);
        eng_op_t op;
        op = ENG_TAP_RESET;
        if (instr == OP_SHIFT_IR) op = ENG_SHIFT_IR;
        if (instr == OP_SHIFT_DR) op = ENG_SHIFT_DR;
        return op;
    endfunction

    function automatic logic [7:0] ack_byte(
        input logic [3:0] instr,
        input logic       timeout,
        input logic       illegal
    );
        logic [7:0] b;
        b = {instr, 4'b0000};
        b[ACK_TIMEOUT_BIT] = timeout;
        b[ACK_ILLEGAL_BIT] = illegal;
        return b;
    endfunction

endpackage

// File: rtl/jtag_cmd_sequencer_if.sv
// Request/response channel between the sequencer and the
// byte-level JTAG shift engine.
interface jtag_cmd_sequencer_if;
    import jtag_cmd_sequencer_pkg::*;

    logic       eng_req_valid;
    logic       eng_req_ready;
    eng_op_t    eng_op;
    logic [7:0] eng_tdi;
    logic       eng_last;
    logic       eng_rsp_valid;
    logic [7:0] eng_rsp_tdo;

    modport master (
        output eng_req_valid,
        input  eng_req_ready,
        output eng_op,
        output eng_tdi,
        output eng_last,
        input  eng_rsp_valid,
        input  eng_rsp_tdo
    );

    modport slave (
        input  eng_req_valid,
        output eng_req_ready,
        input  eng_op,
        input  eng_tdi,
        input  eng_last,
        output eng_rsp_valid,
        output eng_rsp_tdo
    );

endinterface

// File: rtl/jtag_cmd_sequencer.sv
// Pops command descriptors and payload, drives the JTAG engine
// one byte at a time and returns captured TDO plus an ack byte.
module jtag_cmd_sequencer
    import jtag_cmd_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter bit ACK_EN      = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_empty,
    input  logic [3:0] cmd_instr,
    input  logic [7:0] cmd_len,
    output logic       cmd_rd,
    input  logic       data_empty,
    input  logic [7:0] data_byte,
    output logic       data_rd,
    jtag_cmd_sequencer_if.master eng,
    output logic       tx_wr,
    output logic [7:0] tx_byte,
    input  logic [7:0] tx_free,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    instr;
    logic [7:0]    len;
    logic [7:0]    rem;
    logic [7:0]    tdi;
    logic [TW-1:0] tmr;
    logic          to_err;
    logic          ill_err;

    logic [8:0] need;
    logic       start;
    logic       is_shift;
    logic       dec_ill;
    logic       fetch;
    logic       drain_pop;
    logic       handshake;
    logic       rsp_hit;
    logic       timed_out;
    logic       cmd_rd_nxt;
    logic       data_rd_nxt;
    logic       tx_wr_nxt;
    logic [7:0] tx_byte_nxt;

    // A push already in flight is not yet reflected in tx_free.
    always_comb begin
        need = 9'(ACK_EN) + 9'(tx_wr);
        if (cmd_instr == OP_SHIFT_DR) begin
            need = need + {1'b0, cmd_len};
        end
    end

    assign start = (state == S_IDLE) && !cmd_empty
                && ({1'b0, tx_free} >= need);
    assign is_shift = (instr == OP_SHIFT_IR)
                   || (instr == OP_SHIFT_DR);
    assign dec_ill = (instr > OP_SHIFT_DR)
                  || (is_shift && len == 8'd0);
    assign fetch = (state == S_FETCH) && !data_empty;
    // The FIFO head only advances after the pop pulse, so skip a cycle.
    assign drain_pop = (state == S_DRAIN) && (rem != 8'd0)
                    && !data_empty && !data_rd;
    assign handshake = (state == S_ISSUE) && eng.eng_req_ready;
    assign rsp_hit = (state == S_WAIT_RSP) && eng.eng_rsp_valid;
    assign timed_out = (state == S_WAIT_RSP) && !eng.eng_rsp_valid
                    && (tmr == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    dec_ill:               state_nxt = S_DRAIN;
                    (instr == OP_NOP):       state_nxt = S_ACK;
                    (instr == OP_TAP_RESET): state_nxt = S_ISSUE;
                    default:               state_nxt = S_FETCH;
                endcase
            end
            S_FETCH: begin
                if (!data_empty) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (eng.eng_req_ready) state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (rsp_hit) begin
                    state_nxt = (rem != 8'd0) ? S_FETCH : S_ACK;
                end else if (timed_out) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rem == 8'd0) state_nxt = S_ACK;
            end
            S_ACK: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy              = (state != S_IDLE);
        eng.eng_req_valid = (state == S_ISSUE);
        eng.eng_op        = ENG_TAP_RESET;
        eng.eng_tdi       = 8'd0;
        eng.eng_last      = 1'b0;
        if (state == S_ISSUE) begin
            eng.eng_op   = to_eng_op(instr);
            eng.eng_tdi  = tdi;
            eng.eng_last = (rem == 8'd0);
        end
        cmd_rd_nxt  = start;
        data_rd_nxt = fetch || drain_pop;
        tx_wr_nxt   = 1'b0;
        tx_byte_nxt = 8'd0;
        if (rsp_hit && instr == OP_SHIFT_DR) begin
            tx_wr_nxt   = 1'b1;
            tx_byte_nxt = eng.eng_rsp_tdo;
        end else if (state == S_ACK && ACK_EN) begin
            tx_wr_nxt   = 1'b1;
            tx_byte_nxt = ack_byte(instr, to_err, ill_err);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr   <= 4'd0;
            len     <= 8'd0;
            rem     <= 8'd0;
            tdi     <= 8'd0;
            tmr     <= '0;
            to_err  <= 1'b0;
            ill_err <= 1'b0;
            cmd_rd  <= 1'b0;
            data_rd <= 1'b0;
            tx_wr   <= 1'b0;
            tx_byte <= 8'd0;
        end else begin
            cmd_rd  <= cmd_rd_nxt;
            data_rd <= data_rd_nxt;
            tx_wr   <= tx_wr_nxt;
            tx_byte <= tx_byte_nxt;
            if (start) begin
                instr   <= cmd_instr;
                len     <= cmd_len;
                rem     <= cmd_len;
                to_err  <= 1'b0;
                ill_err <= 1'b0;
            end
            if (state == S_DECODE) begin
                ill_err <= dec_ill;
                tdi     <= 8'd0;
                if (!dec_ill && !is_shift) rem <= 8'd0;
            end
            if (fetch) begin
                tdi <= data_byte;
                rem <= rem - 8'd1;
            end
            if (drain_pop) rem <= rem - 8'd1;
            if (handshake) tmr <= '0;
            else if (state == S_WAIT_RSP) tmr <= tmr + 1'b1;
            if (timed_out) to_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_jtag_cmd_sequencer.sv
// Directed bench: FWFT FIFO and echo-engine models with
// scoreboards for TX bytes and engine requests.
module tb_jtag_cmd_sequencer;
    import jtag_cmd_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_empty = 1'b1;
    logic [3:0] cmd_instr = 4'd0;
    logic [7:0] cmd_len = 8'd0;
    logic       cmd_rd;
    logic       data_empty = 1'b1;
    logic [7:0] data_byte = 8'd0;
    logic       data_rd;
    logic       tx_wr;
    logic [7:0] tx_byte;
    logic [7:0] tx_free = 8'd8;
    logic       busy;

    jtag_cmd_sequencer_if eng_bus ();

    jtag_cmd_sequencer #(.TIMEOUT_CYC(16), .ACK_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_empty  (cmd_empty),
        .cmd_instr  (cmd_instr),
        .cmd_len    (cmd_len),
        .cmd_rd     (cmd_rd),
        .data_empty (data_empty),
        .data_byte  (data_byte),
        .data_rd    (data_rd),
        .eng        (eng_bus.master),
        .tx_wr      (tx_wr),
        .tx_byte    (tx_byte),
        .tx_free    (tx_free),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [11:0] cmd_q[$];
    logic [7:0]  data_q[$];
    logic [7:0]  tx_exp[$];
    logic [10:0] eng_exp[$];

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int cmd_pops = 0;
    int data_pops = 0;
    int req_cnt = 0;
    int b2b = 0;
    int stray_at = -1;
    logic withhold = 1'b0;
    logic rsp_pend = 1'b0;
    logic [7:0] pend_tdo = 8'd0;
    logic prev_cmd_rd = 1'b0;
    logic prev_data_rd = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FWFT heads follow the queues within one time unit.
    always begin
        #1;
        cmd_empty  = (cmd_q.size() == 0);
        cmd_instr  = cmd_empty ? 4'd0 : cmd_q[0][11:8];
        cmd_len    = cmd_empty ? 8'd0 : cmd_q[0][7:0];
        data_empty = (data_q.size() == 0);
        data_byte  = data_empty ? 8'd0 : data_q[0];
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd_rd && cmd_q.size() != 0) begin
                void'(cmd_q.pop_front());
                cmd_pops++;
            end
            if (data_rd && data_q.size() != 0) begin
                void'(data_q.pop_front());
                data_pops++;
            end
            if (cmd_rd && prev_cmd_rd) b2b++;
            if (data_rd && prev_data_rd) b2b++;
        end
        prev_cmd_rd  = cmd_rd;
        prev_data_rd = data_rd;
    end

    always @(negedge clk) begin
        logic [10:0] got;
        logic [10:0] want;
        eng_bus.eng_rsp_valid = 1'b0;
        if (rsp_pend) begin
            eng_bus.eng_rsp_valid = 1'b1;
            eng_bus.eng_rsp_tdo   = pend_tdo;
            rsp_pend = 1'b0;
        end else if (cyc == stray_at) begin
            eng_bus.eng_rsp_valid = 1'b1;
            eng_bus.eng_rsp_tdo   = 8'hEE;
        end
        if (!rst && eng_bus.eng_req_valid && eng_bus.eng_req_ready) begin
            req_cnt++;
            got = {eng_bus.eng_op, eng_bus.eng_tdi, eng_bus.eng_last};
            want = (eng_exp.size() != 0) ? eng_exp.pop_front() : 11'h7FF;
            check("eng_req", 32'(got), 32'(want));
            if (!withhold) begin
                rsp_pend = 1'b1;
                pend_tdo = ~eng_bus.eng_tdi;
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] want;
        if (!rst && tx_wr) begin
            want = (tx_exp.size() != 0) ? {1'b0, tx_exp.pop_front()}
                                        : 9'h1FF;
            check("tx_byte", 32'(tx_byte), 32'(want));
            check("tx_free_nz", 32'(tx_free != 8'd0), 32'd1);
        end
    end

    task automatic push_cmd(input logic [3:0] ins,
                            input logic [7:0] ln);
        cmd_q.push_back({ins, ln});
    endtask

    task automatic push_dr(input logic [7:0] b, input logic last);
        data_q.push_back(b);
        eng_exp.push_back({ENG_SHIFT_DR, b, last});
        tx_exp.push_back(~b);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        logic ok;
        n = 0;
        @(negedge clk);
        while ((cmd_q.size() != 0 || busy || tx_wr) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        ok = (n < budget);
        compared++;
        assert (ok === 1'b1) else begin
            mismatched++;
            $error("FAIL %s_wait obs=%0d exp<%0d", tag, n, budget);
        end
    endtask

    initial begin
        int c0, d0, r0, lat, t_hs, k;
        eng_bus.eng_req_ready = 1'b1;
        eng_bus.eng_rsp_valid = 1'b0;
        eng_bus.eng_rsp_tdo   = 8'd0;

        repeat (3) @(negedge clk);
        check("rst_pulses", {29'd0, cmd_rd, data_rd, tx_wr}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_eng", {eng_bus.eng_req_valid, eng_bus.eng_op,
              eng_bus.eng_tdi, eng_bus.eng_last, tx_byte}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // NOP
        c0 = cmd_pops; r0 = req_cnt;
        push_cmd(4'd0, 8'd0);
        tx_exp.push_back(8'h00);
        wait_idle("nop", 50);
        check("nop_cmd_rd", cmd_pops - c0, 1);
        check("nop_no_req", req_cnt - r0, 0);

        // SHIFT_DR 3 bytes, with start-up latency
        d0 = data_pops; r0 = req_cnt;
        push_cmd(4'd3, 8'd3);
        push_dr(8'hA5, 1'b0);
        push_dr(8'h3C, 1'b0);
        push_dr(8'hFF, 1'b1);
        tx_exp.push_back(8'h30);
        lat = 0;
        while (!eng_bus.eng_req_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("dr3_latency", lat, 3);
        wait_idle("dr3", 200);
        check("dr3_data_rd", data_pops - d0, 3);
        check("dr3_reqs", req_cnt - r0, 3);

        // SHIFT_DR 4 bytes held off by tx_free
        tx_free = 8'd3;
        c0 = cmd_pops;
        push_cmd(4'd3, 8'd4);
        push_dr(8'h01, 1'b0);
        push_dr(8'h02, 1'b0);
        push_dr(8'h04, 1'b0);
        push_dr(8'h80, 1'b1);
        tx_exp.push_back(8'h30);
        repeat (12) @(negedge clk);
        check("hold_no_pop", cmd_pops - c0, 0);
        check("hold_idle", 32'(busy), 32'd0);
        tx_free = 8'd5;
        wait_idle("dr4", 200);
        check("dr4_cmd_rd", cmd_pops - c0, 1);

        // Illegal opcode with payload, then NOP
        c0 = cmd_pops; d0 = data_pops; r0 = req_cnt;
        push_cmd(4'd9, 8'd2);
        data_q.push_back(8'h11);
        data_q.push_back(8'h22);
        tx_exp.push_back(8'h91);
        push_cmd(4'd0, 8'd0);
        tx_exp.push_back(8'h00);
        wait_idle("illegal", 100);
        check("ill_data_rd", data_pops - d0, 2);
        check("ill_no_req", req_cnt - r0, 0);
        check("ill_cmd_rd", cmd_pops - c0, 2);

        // Response timeout
        withhold = 1'b1;
        d0 = data_pops; r0 = req_cnt;
        push_cmd(4'd3, 8'd3);
        data_q.push_back(8'h10);
        data_q.push_back(8'h20);
        data_q.push_back(8'h30);
        eng_exp.push_back({ENG_SHIFT_DR, 8'h10, 1'b0});
        tx_exp.push_back(8'h32);
        k = 0;
        while (!(eng_bus.eng_req_valid && eng_bus.eng_req_ready)
               && k < 20) begin
            @(negedge clk);
            k++;
        end
        t_hs = cyc;
        @(negedge clk);
        k = 0;
        while (!data_rd && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("to_abort_cyc", cyc - t_hs, 18);
        wait_idle("timeout", 100);
        check("to_data_rd", data_pops - d0, 3);
        check("to_reqs", req_cnt - r0, 1);
        withhold = 1'b0;
        stray_at = cyc + 2;
        repeat (6) @(negedge clk);
        check("stray_busy", 32'(busy), 32'd0);

        // Reset while a TAP_RESET request is stalled
        eng_bus.eng_req_ready = 1'b0;
        push_cmd(4'd1, 8'd0);
        repeat (20) @(negedge clk);
        check("tap_issue", {eng_bus.eng_req_valid, eng_bus.eng_op,
              eng_bus.eng_tdi, eng_bus.eng_last}, 32'h801);
        rst = 1'b1;
        #1;
        check("mid_rst_out", {cmd_rd, data_rd, tx_wr, tx_byte, busy,
              eng_bus.eng_req_valid, eng_bus.eng_op,
              eng_bus.eng_tdi, eng_bus.eng_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        eng_bus.eng_req_ready = 1'b1;
        r0 = req_cnt;
        push_cmd(4'd2, 8'd1);
        data_q.push_back(8'h5C);
        eng_exp.push_back({ENG_SHIFT_IR, 8'h5C, 1'b1});
        tx_exp.push_back(8'h20);
        wait_idle("post_rst", 100);
        check("ir_reqs", req_cnt - r0, 1);

        check("tx_left", tx_exp.size(), 0);
        check("eng_left", eng_exp.size(), 0);
        check("no_b2b_pop", b2b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
